logit_collector: RTL

Frame collector and initiator for the `argmax` block. It takes the classifier's final-layer logits as a valid/ready stream of `DIM` signed words and buffers them into a vector. It then pulses `start` to a sibling `argmax` instance, waits for `done`, and returns the winning class index on a valid/ready output toward the result sink (e.g. the UART reporter). It owns frame-length checking and an argmax timeout, so a malformed frame or a hung core never wedges the inference path.

---
 rtl/cnn_pkg.sv | 15 +
 rtl/logit_collector.sv | 129 ++++++++++++
 2 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: types and defaults shared across the CNN inference path.
// Holds the logit collector state encoding and the default logit width.
package cnn_pkg;

    localparam int DEF_DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        LC_COLLECT,
        LC_DRAIN,
        LC_START,
        LC_WAIT,
        LC_OUTPUT
    } lc_state_t;

endpackage

// File: rtl/logit_collector.sv
// logit_collector: buffers one frame of logits, kicks argmax, returns the
// winning class; frame-length errors and a hung argmax raise err.
module logit_collector
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DIM        = 10,
    parameter int IDXW       = (DIM <= 1) ? 1 : $clog2(DIM),
    parameter int TIMEOUT    = 1023,
    parameter int CW         = $clog2(TIMEOUT + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic                         am_start,
    output logic signed [DATA_WIDTH-1:0] am_vec [0:DIM-1],
    input  logic        [IDXW-1:0]       am_idx,
    input  logic                         am_done,
    output logic                         out_valid,
    output logic        [IDXW-1:0]       out_idx,
    input  logic                         out_ready,
    output logic                         err,
    output logic                         busy
);

    lc_state_t       state;
    lc_state_t       state_nx;
    logic [IDXW-1:0] cnt;
    logic [CW-1:0]   timer;
    logic [CW-1:0]   timer_nx;
    logic            accept;
    logic            at_end;
    logic            done_ok;
    logic            tmo;
    logic            err_nx;

    assign accept   = in_valid && in_ready;
    assign at_end   = (cnt == IDXW'(DIM - 1));
    assign timer_nx = timer + 1'b1;
    assign tmo      = (timer_nx == CW'(TIMEOUT));
    // timer==0 marks the first WAIT cycle, where done may be stale
    assign done_ok  = (state == LC_WAIT) && am_done && (timer != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LC_COLLECT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            LC_COLLECT: begin
                if (accept && at_end) begin
                    state_nx = in_last ? LC_START : LC_DRAIN;
                end
            end
            LC_DRAIN: begin
                if (accept && in_last) begin
                    state_nx = LC_COLLECT;
                end
            end
            LC_START: state_nx = LC_WAIT;
            LC_WAIT: begin
                if (done_ok) begin
                    state_nx = LC_OUTPUT;
                end else if (tmo) begin
                    state_nx = LC_COLLECT;
                end
            end
            LC_OUTPUT: begin
                if (out_ready) begin
                    state_nx = LC_COLLECT;
                end
            end
            default: state_nx = LC_COLLECT;
        endcase
    end

    always_comb begin
        in_ready  = (state == LC_COLLECT) || (state == LC_DRAIN);
        am_start  = (state == LC_START);
        out_valid = (state == LC_OUTPUT);
        busy      = (state != LC_COLLECT);
    end

    // short frame: last before the end; long frame: end without last
    always_comb begin
        err_nx = 1'b0;
        if ((state == LC_COLLECT) && accept && (in_last != at_end)) begin
            err_nx = 1'b1;
        end
        if ((state == LC_WAIT) && !done_ok && tmo) begin
            err_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            timer   <= '0;
            out_idx <= '0;
            err     <= 1'b0;
            for (int i = 0; i < DIM; i++) begin
                am_vec[i] <= '0;
            end
        end else begin
            err <= err_nx;
            if ((state == LC_COLLECT) && accept) begin
                am_vec[cnt] <= in_data;
                cnt         <= (in_last || at_end) ? '0 : cnt + 1'b1;
            end
            if (state == LC_START) begin
                timer <= '0;
            end else if (state == LC_WAIT) begin
                timer <= timer_nx;
            end
            if (done_ok) begin
                out_idx <= am_idx;
            end
        end
    end

endmodule
